operand_entry: RTL and testbench
================================

Name: operand_entry

Overview:
- Sits directly downstream of the button debounce/toggle stage.
- Consumes four debounced button levels from the NANDLAND board and turns their press edges into calculator input: two 2-digit decimal operands and an operator code.
- Presents the completed request to the arithmetic stage over a valid/ready handshake.
- Drives BCD digits and cursor position for the two-digit seven-segment display stage.

Parameters:
NUM_OPS, 4, number of operator codes; op cycles 0..NUM_OPS-1 (0=add, 1=sub, 2=mul, 3=div).

Ports:
clk  input  1  system clock (25 MHz board clock)
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
btn_inc  input  1  debounced level, 1=pressed; increments the digit under the cursor
btn_next  input  1  debounced level; toggles the cursor between ones and tens
btn_op  input  1  debounced level; cycles the operator code
btn_enter  input  1  debounced level; advances A->B, then B->request
req_valid  output  1  request handshake valid
req_ready  input  1  arithmetic stage accepts the request
operand_a  output  7  binary value of operand A (0..99)
operand_b  output  7  binary value of operand B (0..99)
op_code  output  2  selected operator
disp_tens  output  4  BCD tens digit of the operand being edited
disp_ones  output  4  BCD ones digit of the operand being edited
cursor  output  1  0=ones digit selected, 1=tens digit selected
entering_b  output  1  1 while operand B is being edited or requested

Behaviour:
- Reset (rst_n=0 at a clk edge): state=ENTER_A; all digits=0; op_code=0; cursor=0; req_valid=0; entering_b=0; operand_a=operand_b=0.
  - Edge-history registers reset to 1, so a button held through reset produces no press.
- Press detection:
  - press = level & ~prev; prev is a register updated every cycle in every state.
  - The resulting action is visible on outputs 1 cycle after the first cycle the level is sampled high.
  - One press per low->high transition; holding a button produces no repeat.
- Simultaneous presses in one cycle: only the highest-priority press acts (enter > op > next > inc); the others are discarded, not queued.
- States:
  - ENTER_A: inc/next/op act on A. enter -> ENTER_B, with B digits cleared and cursor=0.
  - ENTER_B: inc/next/op act on B. enter -> REQ.
  - REQ: req_valid=1. All presses are ignored, but edge history still updates. On req_valid&req_ready -> ENTER_A, with A and B digits cleared, cursor=0 and op_code retained.
- inc: selected digit +1 modulo 10 (9 -> 0); no carry into the other digit.
- next: cursor toggles.
- op: op_code +1 modulo NUM_OPS (3 -> 0).
- Arithmetic and width rules:
  - operand_x = tens*10 + ones, registered when the state enters REQ.
  - Maximum value 99 fits in 7 bits.
  - operand_a, operand_b and op_code hold stable for the whole time req_valid=1 and after acceptance until the next REQ entry.
- Handshake:
  - req_valid stays high until accepted and never drops without req_ready.
  - req_ready while req_valid=0 has no effect.
  - Acceptance and a press in the same cycle: the press is ignored.
- Display:
  - disp_* shows A digits in ENTER_A and B digits in ENTER_B/REQ.
  - entering_b=1 in ENTER_B and REQ.
- Reset mid-operation, including during REQ: next cycle is the full reset state; req_valid=0 with no handshake completion.
- Digit registers only ever hold 0..9; an illegal encoding is unreachable, and any other state encoding recovers to ENTER_A.

Test Plan:
- Reset with btn_inc held high, then held 10 cycles -> disp_ones=0, no press registered; release then press -> disp_ones=1 one cycle after press sampled.
- In ENTER_A press inc x3, next, inc x4, then enter -> disp shows 4/3 before enter; after enter entering_b=1, disp 0/0, cursor=0.
- Enter B=9 by pressing inc x9, then inc once more -> ones wraps 9->0, tens stays 0; op pressed x5 -> op_code=1.
- A=43, B=7, op=2, enter with req_ready=0 for 5 cycles -> req_valid held, operand_a=43, operand_b=7, op_code=2, presses ignored; ready=1 -> next cycle ENTER_A, req_valid=0, digits 0, op_code=2.
- inc and enter rise in the same cycle in ENTER_A -> only the state change to ENTER_B occurs; A ones unchanged.
- rst_n=0 for one cycle while req_valid=1 -> next cycle req_valid=0, state ENTER_A, op_code=0, all digits 0.

Source files
------------

// File: rtl/operand_entry.sv
// operand_entry: button press edges to two 2-digit BCD operands plus operator, handed off over valid/ready
module operand_entry #(
    parameter int NUM_OPS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_inc,
    input  logic       btn_next,
    input  logic       btn_op,
    input  logic       btn_enter,
    output logic       req_valid,
    input  logic       req_ready,
    output logic [6:0] operand_a,
    output logic [6:0] operand_b,
    output logic [1:0] op_code,
    output logic [3:0] disp_tens,
    output logic [3:0] disp_ones,
    output logic       cursor,
    output logic       entering_b
);
    typedef enum logic [1:0] {ENTER_A, ENTER_B, REQ} state_t;
    state_t     state, state_n;
    logic [3:0] lvl, prev, pr;
    logic [3:0] a_t, a_o, b_t, b_o, a_t_n, a_o_n, b_t_n, b_o_n;
    logic [1:0] op_n;
    logic       cursor_n;
    logic [6:0] oa_n, ob_n;

    function automatic logic [3:0] inc10(input logic [3:0] d);
        return d >= 4'd9 ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [6:0] bin(input logic [3:0] t, input logic [3:0] o);
        return 7'(t) * 7'd10 + 7'(o);
    endfunction

    assign lvl        = {btn_enter, btn_op, btn_next, btn_inc};
    assign pr         = lvl & ~prev;
    assign req_valid  = state == REQ;
    assign entering_b = state == ENTER_B || state == REQ;
    assign disp_tens  = entering_b ? b_t : a_t;
    assign disp_ones  = entering_b ? b_o : a_o;

    always_comb begin
        state_n  = state;
        a_t_n    = a_t;
        a_o_n    = a_o;
        b_t_n    = b_t;
        b_o_n    = b_o;
        op_n     = op_code;
        cursor_n = cursor;
        oa_n     = operand_a;
        ob_n     = operand_b;
        case (state)
            ENTER_A, ENTER_B: begin
                if (pr[3]) begin
                    if (state == ENTER_A) begin
                        state_n  = ENTER_B;
                        b_t_n    = 4'd0;
                        b_o_n    = 4'd0;
                        cursor_n = 1'b0;
                    end else begin
                        state_n = REQ;
                        oa_n    = bin(a_t, a_o);
                        ob_n    = bin(b_t, b_o);
                    end
                end else if (pr[2]) begin
                    op_n = op_code == 2'(NUM_OPS - 1) ? 2'd0 : op_code + 2'd1;
                end else if (pr[1]) begin
                    cursor_n = ~cursor;
                end else if (pr[0]) begin
                    if (state == ENTER_A) begin
                        a_t_n = cursor ? inc10(a_t) : a_t;
                        a_o_n = cursor ? a_o : inc10(a_o);
                    end else begin
                        b_t_n = cursor ? inc10(b_t) : b_t;
                        b_o_n = cursor ? b_o : inc10(b_o);
                    end
                end
            end
            REQ: begin
                if (req_ready) begin
                    state_n  = ENTER_A;
                    a_t_n    = 4'd0;
                    a_o_n    = 4'd0;
                    b_t_n    = 4'd0;
                    b_o_n    = 4'd0;
                    cursor_n = 1'b0;
                end
            end
            default: state_n = ENTER_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ENTER_A;
            prev      <= 4'hf;
            a_t       <= 4'd0;
            a_o       <= 4'd0;
            b_t       <= 4'd0;
            b_o       <= 4'd0;
            op_code   <= 2'd0;
            cursor    <= 1'b0;
            operand_a <= 7'd0;
            operand_b <= 7'd0;
        end else begin
            state     <= state_n;
            prev      <= lvl;
            a_t       <= a_t_n;
            a_o       <= a_o_n;
            b_t       <= b_t_n;
            b_o       <= b_o_n;
            op_code   <= op_n;
            cursor    <= cursor_n;
            operand_a <= oa_n;
            operand_b <= ob_n;
        end
    end
endmodule

// File: tb/tb_operand_entry.sv
// tb_operand_entry: directed and random button sequences checked against a behavioural calculator-entry model
module tb_operand_entry;
    logic       clk = 1'b0;
    logic       rst_n, btn_inc, btn_next, btn_op, btn_enter, req_ready;
    logic       req_valid, cursor, entering_b;
    logic [6:0] operand_a, operand_b;
    logic [1:0] op_code;
    logic [3:0] disp_tens, disp_ones;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         phase, m_op, m_cur, m_oa, m_ob;
    int         dig[2][2];
    bit [3:0]   pv;
    logic [3:0] lv;

    operand_entry #(.NUM_OPS(4)) dut (
        .clk(clk), .rst_n(rst_n), .btn_inc(btn_inc), .btn_next(btn_next),
        .btn_op(btn_op), .btn_enter(btn_enter), .req_valid(req_valid),
        .req_ready(req_ready), .operand_a(operand_a), .operand_b(operand_b),
        .op_code(op_code), .disp_tens(disp_tens), .disp_ones(disp_ones),
        .cursor(cursor), .entering_b(entering_b)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit rn, input bit [3:0] l, input bit rdy);
        bit [3:0] p;
        int       w;
        if (!rn) begin
            phase = 0; m_op = 0; m_cur = 0; m_oa = 0; m_ob = 0; pv = 4'hf;
            dig = '{'{0, 0}, '{0, 0}};
            return;
        end
        p  = l & ~pv;
        pv = l;
        w  = phase == 0 ? 0 : 1;
        if (phase == 2) begin
            if (rdy) begin
                phase = 0; m_cur = 0;
                dig = '{'{0, 0}, '{0, 0}};
            end
        end else if (p[3]) begin
            if (phase == 0) begin
                phase = 1; m_cur = 0; dig[1] = '{0, 0};
            end else begin
                phase = 2;
                m_oa = dig[0][1] * 10 + dig[0][0];
                m_ob = dig[1][1] * 10 + dig[1][0];
            end
        end else if (p[2]) m_op = (m_op + 1) % 4;
        else if (p[1]) m_cur = 1 - m_cur;
        else if (p[0]) dig[w][m_cur] = (dig[w][m_cur] + 1) % 10;
    endtask

    task automatic step(input bit rn, input bit [3:0] l, input bit rdy);
        int w;
        rst_n = rn; {btn_enter, btn_op, btn_next, btn_inc} = l; req_ready = rdy;
        @(posedge clk);
        model(rn, l, rdy);
        #1;
        w = phase == 0 ? 0 : 1;
        check("req_valid", req_valid, phase == 2);
        check("entering_b", entering_b, phase != 0);
        check("cursor", cursor, m_cur);
        check("op_code", op_code, m_op);
        check("disp_tens", disp_tens, dig[w][1]);
        check("disp_ones", disp_ones, dig[w][0]);
        check("operand_a", operand_a, m_oa);
        check("operand_b", operand_b, m_ob);
    endtask

    task automatic tap(input int b, input int n);
        for (int i = 0; i < n; i++) begin
            step(1, 4'(1 << b), 0);
            step(1, 4'h0, 0);
        end
    endtask

    initial begin
        step(0, 4'h1, 0);
        step(0, 4'h1, 0);
        for (int i = 0; i < 10; i++) step(1, 4'h1, 0);
        check("held_through_reset", disp_ones, 0);
        step(1, 4'h0, 0);
        step(1, 4'h1, 0);
        check("first_press", disp_ones, 1);
        step(0, 4'h0, 0);
        step(1, 4'h0, 0);
        tap(0, 3); tap(1, 1); tap(0, 4);
        check("a_tens", disp_tens, 4);
        check("a_ones", disp_ones, 3);
        tap(3, 1);
        check("to_b", entering_b, 1);
        check("b_clear", {disp_tens, disp_ones}, 0);
        check("b_cursor", cursor, 0);
        tap(0, 9);
        check("b_nine", disp_ones, 9);
        tap(0, 1);
        check("wrap_ones", disp_ones, 0);
        check("wrap_tens", disp_tens, 0);
        tap(2, 5);
        check("op_wrap", op_code, 1);
        step(0, 4'h0, 0);
        step(1, 4'h0, 0);
        tap(0, 3); tap(1, 1); tap(0, 4); tap(2, 2); tap(3, 1); tap(0, 7);
        step(1, 4'h8, 0);
        for (int i = 0; i < 5; i++) step(1, i % 2 ? 4'h7 : 4'h0, 0);
        check("req_hold", req_valid, 1);
        check("opa_43", operand_a, 43);
        check("opb_7", operand_b, 7);
        check("op_2", op_code, 2);
        step(1, 4'h1, 1);
        check("accepted", req_valid, 0);
        check("back_a", entering_b, 0);
        check("acc_ones", disp_ones, 0);
        check("op_kept", op_code, 2);
        step(1, 4'h0, 0);
        step(1, 4'h9, 0);
        check("simul_enter", entering_b, 1);
        step(1, 4'h0, 0);
        tap(3, 1);
        check("simul_a_ones", operand_a, 0);
        step(0, 4'h0, 0);
        check("rst_in_req", req_valid, 0);
        check("rst_op", op_code, 0);
        for (int i = 0; i < 3000; i++) begin
            lv = {btn_enter, btn_op, btn_next, btn_inc};
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 3) == 0) lv[b] = ~lv[b];
            step($urandom_range(0, 199) != 0, lv, $urandom_range(0, 2) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
